// File: rtl/csm_pkg.sv
// Shared types for the CSM request front end: core operations, client commands,
// lock ownership and the arbiter FSM states.
package csm_pkg;

  typedef enum logic [3:0] {
    rst     = 4'd0,
    a_read  = 4'd1,
    a_write = 4'd2,
    a_hold  = 4'd3,
    a_relse = 4'd4,
    b_read  = 4'd5,
    b_write = 4'd6,
    b_hold  = 4'd7,
    b_relse = 4'd8
  } operation_t;

  typedef enum logic [1:0] {
    cmd_read  = 2'd0,
    cmd_write = 2'd1,
    cmd_hold  = 2'd2,
    cmd_relse = 2'd3
  } req_cmd_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;

  // Client operations are laid out as base + cmd, so the mapping is an offset.
  function automatic operation_t to_op(owner_t client, req_cmd_t cmd);
    operation_t res;
    res = rst;
    if (client == OWN_A) begin
      res = operation_t'(4'd1 + {2'b00, cmd});
    end else if (client == OWN_B) begin
      res = operation_t'(4'd5 + {2'b00, cmd});
    end
    return res;
  endfunction

endpackage

// File: rtl/csm_req_arbiter_if.sv
// Client request, soft-reset and core command signals of the CSM front end.
// master = arbiter side, slave = clients plus core side.
interface csm_req_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  import csm_pkg::*;

  logic              a_req;
  req_cmd_t          a_cmd;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic              a_err;

  logic              b_req;
  req_cmd_t          b_cmd;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic              b_err;

  logic              soft_rst;

  operation_t        op;
  logic              op_valid;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              op_ready;
  owner_t            owner;

  modport master (
    input  a_req, a_cmd, a_addr, a_wdata,
    input  b_req, b_cmd, b_addr, b_wdata,
    input  soft_rst, op_ready,
    output a_ack, a_err, b_ack, b_err,
    output op, op_valid, op_addr, op_wdata, owner
  );

  modport slave (
    output a_req, a_cmd, a_addr, a_wdata,
    output b_req, b_cmd, b_addr, b_wdata,
    output soft_rst, op_ready,
    input  a_ack, a_err, b_ack, b_err,
    input  op, op_valid, op_addr, op_wdata, owner
  );

endinterface

// File: rtl/csm_client_gate.sv
// Per-client lock check: classifies a pending request as eligible, stalled
// (other client owns the lock) or rejected (bad hold/relse).
module csm_client_gate
  import csm_pkg::*;
#(
  parameter owner_t SELF = OWN_A
) (
  input  logic     req_i,
  input  req_cmd_t cmd_i,
  input  owner_t   owner_i,
  input  logic     ack_i,
  output logic     eligible_o,
  output logic     stalled_o,
  output logic     reject_o
);

  logic live;
  logic other_owns;
  logic bad_cmd;

  // A request acked this cycle is the one just completed, not a new one.
  assign live       = req_i && !ack_i;
  assign other_owns = (owner_i != OWN_NONE) && (owner_i != SELF);
  assign bad_cmd    = ((cmd_i == cmd_relse) && (owner_i != SELF)) ||
                      ((cmd_i == cmd_hold)  && (owner_i == SELF));

  assign stalled_o  = live && other_owns;
  assign reject_o   = live && !other_owns && bad_cmd;
  assign eligible_o = live && !other_owns && !bad_cmd;

endmodule

// File: rtl/csm_req_arbiter.sv
// Two-client lock-aware arbiter issuing one operation_t at a time to the CSM core.
// state    | meaning
// ST_IDLE  | evaluate requests/soft reset, reject bad ones, pick one to issue
// ST_ISSUE | command held on op until op_ready; ack and owner update at handshake
module csm_req_arbiter
  import csm_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  csm_req_arbiter_if.master bus
);

  arb_state_t        state_q, state_d;
  operation_t        op_q, op_d;
  logic              op_valid_q, op_valid_d;
  logic [ADDR_W-1:0] op_addr_q, op_addr_d;
  logic [DATA_W-1:0] op_wdata_q, op_wdata_d;
  logic              a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic              b_ack_q, b_ack_d, b_err_q, b_err_d;
  owner_t            owner_q, owner_d;
  logic              rr_q, rr_d;
  logic              rst_pend_q, rst_pend_d;

  logic a_elig, a_stall, a_rej;
  logic b_elig, b_stall, b_rej;
  logic pick_b;

  csm_client_gate #(.SELF(OWN_A)) u_gate_a (
    .req_i      (bus.a_req),
    .cmd_i      (bus.a_cmd),
    .owner_i    (owner_q),
    .ack_i      (a_ack_q),
    .eligible_o (a_elig),
    .stalled_o  (a_stall),
    .reject_o   (a_rej)
  );

  csm_client_gate #(.SELF(OWN_B)) u_gate_b (
    .req_i      (bus.b_req),
    .cmd_i      (bus.b_cmd),
    .owner_i    (owner_q),
    .ack_i      (b_ack_q),
    .eligible_o (b_elig),
    .stalled_o  (b_stall),
    .reject_o   (b_rej)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    op_valid_d = op_valid_q;
    op_addr_d  = op_addr_q;
    op_wdata_d = op_wdata_q;
    a_ack_d    = 1'b0;
    a_err_d    = 1'b0;
    b_ack_d    = 1'b0;
    b_err_d    = 1'b0;
    owner_d    = owner_q;
    rr_d       = rr_q;
    rst_pend_d = rst_pend_q;
    pick_b     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        a_ack_d = a_rej;
        a_err_d = a_rej;
        b_ack_d = b_rej;
        b_err_d = b_rej;
        if (rst_pend_q || bus.soft_rst) begin
          op_d       = rst;
          op_addr_d  = '0;
          op_wdata_d = '0;
          op_valid_d = 1'b1;
          state_d    = ST_ISSUE;
        end else if (a_elig || b_elig) begin
          // rr_q = 0 favours A on contention, 1 favours B
          pick_b = b_elig && (!a_elig || rr_q);
          if (a_elig && b_elig) begin
            rr_d = !rr_q;
          end
          if (pick_b) begin
            op_d       = to_op(OWN_B, bus.b_cmd);
            op_addr_d  = bus.b_addr;
            op_wdata_d = bus.b_wdata;
          end else begin
            op_d       = to_op(OWN_A, bus.a_cmd);
            op_addr_d  = bus.a_addr;
            op_wdata_d = bus.a_wdata;
          end
          op_valid_d = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.op_ready) begin
          op_valid_d = 1'b0;
          state_d    = ST_IDLE;
          case (op_q)
            a_read, a_write: a_ack_d = 1'b1;
            a_hold:  begin a_ack_d = 1'b1; owner_d = OWN_A;    end
            a_relse: begin a_ack_d = 1'b1; owner_d = OWN_NONE; end
            b_read, b_write: b_ack_d = 1'b1;
            b_hold:  begin b_ack_d = 1'b1; owner_d = OWN_B;    end
            b_relse: begin b_ack_d = 1'b1; owner_d = OWN_NONE; end
            default: begin owner_d = OWN_NONE; rst_pend_d = 1'b0; end
          endcase
        end
        if (bus.soft_rst) begin
          rst_pend_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= rst;
      op_valid_q <= 1'b0;
      op_addr_q  <= '0;
      op_wdata_q <= '0;
      a_ack_q    <= 1'b0;
      a_err_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      b_err_q    <= 1'b0;
      owner_q    <= OWN_NONE;
      rr_q       <= 1'b0;
      rst_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      op_addr_q  <= op_addr_d;
      op_wdata_q <= op_wdata_d;
      a_ack_q    <= a_ack_d;
      a_err_q    <= a_err_d;
      b_ack_q    <= b_ack_d;
      b_err_q    <= b_err_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      rst_pend_q <= rst_pend_d;
    end
  end

  a_gate_excl: assert property (@(posedge clk) disable iff (!rst_n)
                                !(a_stall && (a_elig || a_rej)));
  b_gate_excl: assert property (@(posedge clk) disable iff (!rst_n)
                                !(b_stall && (b_elig || b_rej)));

  assign bus.op       = op_q;
  assign bus.op_valid = op_valid_q;
  assign bus.op_addr  = op_addr_q;
  assign bus.op_wdata = op_wdata_q;
  assign bus.a_ack    = a_ack_q;
  assign bus.a_err    = a_err_q;
  assign bus.b_ack    = b_ack_q;
  assign bus.b_err    = b_err_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_csm_req_arbiter.sv
// Bench for csm_req_arbiter: directed lock/arbitration scenarios, then random
// client traffic compared each cycle against a transaction-level model.
module tb_csm_req_arbiter;
  import csm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csm_req_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  csm_req_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int c, input int req, input int cmd, input int addr, input int wd);
    if (c == 0) begin
      bus.a_req   = (req != 0);
      bus.a_cmd   = req_cmd_t'(cmd[1:0]);
      bus.a_addr  = addr[3:0];
      bus.a_wdata = wd[7:0];
    end else begin
      bus.b_req   = (req != 0);
      bus.b_cmd   = req_cmd_t'(cmd[1:0]);
      bus.b_addr  = addr[3:0];
      bus.b_wdata = wd[7:0];
    end
  endtask

  task automatic wait_op(input string tag, input int exp_op, input int exp_addr, input int exp_wd);
    int n = 0;
    while (!bus.op_valid && n < 20) begin
      tick();
      n++;
    end
    chk_eq({tag, "_valid"}, bus.op_valid, 1);
    chk_eq({tag, "_op"}, bus.op, exp_op);
    chk_eq({tag, "_addr"}, bus.op_addr, exp_addr);
    chk_eq({tag, "_wdata"}, bus.op_wdata, exp_wd);
  endtask

  task automatic wait_ack(input int c, input string tag, input int exp_err);
    int n = 0;
    while (((c == 0) ? bus.a_ack : bus.b_ack) == 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk_eq({tag, "_ack"}, (c == 0) ? bus.a_ack : bus.b_ack, 1);
    chk_eq({tag, "_err"}, (c == 0) ? bus.a_err : bus.b_err, exp_err);
    set_req(c, 0, 0, 0, 0);
  endtask

  // Transaction-level reference: one in-flight transaction (source client and
  // command, or -1 for a soft reset), lock owner 0/1/2, contention pointer.
  int r_req[2], r_cmd[2], r_addr[2], r_wd[2];
  int r_ready, r_soft;
  int m_busy, m_src, m_kind, m_op, m_addr, m_wd, m_owner, m_rr, m_pend;
  int m_ack[2], m_err[2];

  task automatic model_reset();
    m_busy = 0; m_src = -1; m_kind = 0; m_op = 0; m_addr = 0; m_wd = 0;
    m_owner = 0; m_rr = 0; m_pend = 0;
    for (int c = 0; c < 2; c++) begin
      m_ack[c] = 0;
      m_err[c] = 0;
    end
  endtask

  task automatic model_step();
    int nack[2], nerr[2], ok[2];
    int live, other, bad, win;
    for (int c = 0; c < 2; c++) begin
      nack[c] = 0;
      nerr[c] = 0;
      ok[c]   = 0;
    end
    if (m_busy == 0) begin
      for (int c = 0; c < 2; c++) begin
        live  = (r_req[c] != 0 && m_ack[c] == 0) ? 1 : 0;
        other = (m_owner != 0 && m_owner != c + 1) ? 1 : 0;
        bad   = ((r_cmd[c] == 3 && m_owner != c + 1) || (r_cmd[c] == 2 && m_owner == c + 1)) ? 1 : 0;
        ok[c]   = (live == 1 && other == 0 && bad == 0) ? 1 : 0;
        nack[c] = (live == 1 && other == 0 && bad == 1) ? 1 : 0;
        nerr[c] = nack[c];
      end
      if (m_pend != 0 || r_soft != 0) begin
        m_op = 0; m_addr = 0; m_wd = 0; m_src = -1; m_busy = 1;
      end else begin
        win = -1;
        if (ok[0] == 1 && ok[1] == 1) begin
          win  = m_rr;
          m_rr = 1 - m_rr;
        end else if (ok[0] == 1) win = 0;
        else if (ok[1] == 1) win = 1;
        if (win >= 0) begin
          m_src  = win;
          m_kind = r_cmd[win];
          m_op   = 1 + 4 * win + r_cmd[win];
          m_addr = r_addr[win];
          m_wd   = r_wd[win];
          m_busy = 1;
        end
      end
    end else begin
      if (r_ready != 0) begin
        m_busy = 0;
        if (m_src >= 0) begin
          nack[m_src] = 1;
          if (m_kind == 2) m_owner = m_src + 1;
          if (m_kind == 3) m_owner = 0;
        end else begin
          m_owner = 0;
          m_pend  = 0;
        end
      end
      if (r_soft != 0) m_pend = 1;
    end
    for (int c = 0; c < 2; c++) begin
      m_ack[c] = nack[c];
      m_err[c] = nerr[c];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nk, nv, n;
    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    bus.soft_rst = 1'b0;
    bus.op_ready = 1'b1;
    repeat (3) tick();
    chk_eq("rst_op", bus.op, 0);
    chk_eq("rst_valid", bus.op_valid, 0);
    chk_eq("rst_addr", bus.op_addr, 0);
    chk_eq("rst_owner", bus.owner, 0);
    chk_eq("rst_acks", {bus.a_ack, bus.a_err, bus.b_ack, bus.b_err}, 0);
    rst_n = 1'b1;
    tick();

    // single read latency
    set_req(0, 1, 0, 3, 0);
    tick();
    chk_eq("rd_valid_n1", bus.op_valid, 1);
    chk_eq("rd_op_n1", bus.op, a_read);
    chk_eq("rd_addr_n1", bus.op_addr, 3);
    tick();
    chk_eq("rd_ack_n2", bus.a_ack, 1);
    chk_eq("rd_err_n2", bus.a_err, 0);
    chk_eq("rd_valid_n2", bus.op_valid, 0);
    set_req(0, 0, 0, 0, 0);
    tick();

    // contention: A first, then pointer favours B
    set_req(0, 1, 1, 1, 'h11);
    set_req(1, 1, 1, 2, 'h22);
    wait_op("ab_first", a_write, 1, 'h11);
    wait_ack(0, "ab_first", 0);
    wait_op("ab_second", b_write, 2, 'h22);
    wait_ack(1, "ab_second", 0);
    tick();
    set_req(0, 1, 0, 4, 0);
    set_req(1, 1, 0, 5, 0);
    wait_op("ba_first", b_read, 5, 0);
    wait_ack(1, "ba_first", 0);
    wait_op("ba_second", a_read, 4, 0);
    wait_ack(0, "ba_second", 0);

    // lock ownership and stall
    set_req(0, 1, 2, 0, 0);
    wait_op("hold", a_hold, 0, 0);
    wait_ack(0, "hold", 0);
    chk_eq("hold_owner", bus.owner, 1);
    set_req(1, 1, 1, 5, 'h55);
    nk = 0; nv = 0;
    repeat (10) begin
      tick();
      nk += int'(bus.b_ack);
      nv += int'(bus.op_valid);
    end
    chk_eq("stall_b_ack", nk, 0);
    chk_eq("stall_valid", nv, 0);
    set_req(0, 1, 1, 7, 'h77);
    wait_op("own_wr", a_write, 7, 'h77);
    wait_ack(0, "own_wr", 0);
    chk_eq("own_keep", bus.owner, 1);
    set_req(0, 1, 3, 0, 0);
    wait_op("relse", a_relse, 0, 0);
    wait_ack(0, "relse", 0);
    chk_eq("relse_owner", bus.owner, 0);
    n = 0;
    while (!bus.op_valid && n < 2) begin
      tick();
      n++;
    end
    chk_eq("unstall_valid", bus.op_valid, 1);
    chk_eq("unstall_op", bus.op, b_write);
    chk_eq("unstall_wdata", bus.op_wdata, 'h55);
    wait_ack(1, "unstall", 0);
    tick();

    // rejections
    set_req(1, 1, 3, 0, 0);
    tick();
    chk_eq("brel_ack", bus.b_ack, 1);
    chk_eq("brel_err", bus.b_err, 1);
    chk_eq("brel_valid", bus.op_valid, 0);
    set_req(1, 0, 0, 0, 0);
    set_req(0, 1, 2, 0, 0);
    wait_op("hold1", a_hold, 0, 0);
    wait_ack(0, "hold1", 0);
    tick();
    set_req(0, 1, 2, 0, 0);
    tick();
    chk_eq("hold2_ack", bus.a_ack, 1);
    chk_eq("hold2_err", bus.a_err, 1);
    chk_eq("hold2_valid", bus.op_valid, 0);
    set_req(0, 0, 0, 0, 0);
    tick();
    chk_eq("hold2_owner", bus.owner, 1);

    // backpressure with soft reset arriving during ISSUE
    bus.op_ready = 1'b0;
    set_req(0, 1, 0, 9, 0);
    set_req(1, 1, 0, 4, 0);
    wait_op("bp", a_read, 9, 0);
    nk = 0;
    for (int i = 0; i < 5; i++) begin
      bus.soft_rst = (i == 1);
      tick();
      chk_eq("bp_op", bus.op, a_read);
      chk_eq("bp_addr", bus.op_addr, 9);
      chk_eq("bp_valid", bus.op_valid, 1);
    end
    bus.soft_rst = 1'b0;
    bus.op_ready = 1'b1;
    wait_ack(0, "bp", 0);
    wait_op("srst", rst, 0, 0);
    tick();
    chk_eq("srst_owner", bus.owner, 0);
    chk_eq("srst_no_ack", {bus.a_ack, bus.b_ack}, 0);
    wait_op("b_after", b_read, 4, 0);
    wait_ack(1, "b_after", 0);
    tick();

    // async reset while a command is in flight
    set_req(0, 1, 2, 0, 0);
    wait_op("pre_hold", a_hold, 0, 0);
    wait_ack(0, "pre_hold", 0);
    tick();
    bus.op_ready = 1'b0;
    set_req(0, 1, 0, 2, 0);
    wait_op("pre_rst", a_read, 2, 0);
    chk_eq("pre_rst_owner", bus.owner, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("async_valid", bus.op_valid, 0);
    chk_eq("async_owner", bus.owner, 0);
    chk_eq("async_acks", {bus.a_ack, bus.b_ack}, 0);
    set_req(0, 0, 0, 0, 0);
    bus.op_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    nk = 0;
    repeat (4) begin
      tick();
      nk += int'(bus.a_ack) + int'(bus.b_ack) + int'(bus.op_valid);
    end
    chk_eq("no_stale_ack", nk, 0);

    // random traffic against the model
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      r_req[c] = 0; r_cmd[c] = 0; r_addr[c] = 0; r_wd[c] = 0;
    end
    model_reset();
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (r_req[c] != 0 && m_ack[c] != 0) begin
          r_req[c] = 0;
        end else if (r_req[c] == 0 && $urandom_range(0, 2) == 0) begin
          r_req[c]  = 1;
          r_cmd[c]  = int'($urandom_range(0, 3));
          r_addr[c] = int'($urandom_range(0, 15));
          r_wd[c]   = int'($urandom_range(0, 255));
        end
        set_req(c, r_req[c], r_cmd[c], r_addr[c], r_wd[c]);
      end
      r_ready = ($urandom_range(0, 3) != 0) ? 1 : 0;
      r_soft  = ($urandom_range(0, 39) == 0) ? 1 : 0;
      bus.op_ready = (r_ready != 0);
      bus.soft_rst = (r_soft != 0);
      model_step();
      tick();
      chk_eq("rnd_valid", bus.op_valid, m_busy);
      chk_eq("rnd_op", bus.op, m_op);
      chk_eq("rnd_addr", bus.op_addr, m_addr);
      chk_eq("rnd_wdata", bus.op_wdata, m_wd);
      chk_eq("rnd_owner", bus.owner, m_owner);
      chk_eq("rnd_a_ack", bus.a_ack, m_ack[0]);
      chk_eq("rnd_a_err", bus.a_err, m_err[0]);
      chk_eq("rnd_b_ack", bus.b_ack, m_ack[1]);
      chk_eq("rnd_b_err", bus.b_err, m_err[1]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/csm_req_arbiter.md
Name: csm_req_arbiter

Overview:
- Upstream front end of the CSM core: accepts read/write/hold/release requests from two clients (A, B), enforces lock ownership and arbitrates between them.
- Issues one `operation_t` command at a time to the core over a valid/ready handshake.
- Also injects the `rst` operation on a synchronous soft-reset request.

Parameters:
- ADDR_W, 4, width of request/command address.
- DATA_W, 8, width of write data.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  client A request valid; held until a_ack
- a_cmd  in  2  client A command, req_cmd_t: 0 read, 1 write, 2 hold, 3 relse
- a_addr  in  ADDR_W  client A address
- a_wdata  in  DATA_W  client A write data
- a_ack  out  1  one-cycle pulse: A request completed or rejected
- a_err  out  1  one-cycle pulse with a_ack: A request rejected
- b_req, b_cmd, b_addr, b_wdata, b_ack, b_err  same as A, for client B
- soft_rst  in  1  request to issue the `rst` operation
- op  out  4  `operation_t` command to core
- op_valid  out  1  command valid
- op_addr  out  ADDR_W  command address
- op_wdata  out  DATA_W  command write data
- op_ready  in  1  core accepts command
- owner  out  2  owner_t: 0 NONE, 1 A, 2 B

Behaviour:
Reset (rst_n low, asynchronous) sets:
- op=`rst`, op_valid=0, op_addr=0, op_wdata=0.
- All acks and errs = 0.
- owner=NONE, round-robin pointer=A, rst_pend=0, state=IDLE.
- An in-flight command is dropped without an ack.

FSM has two states, IDLE and ISSUE; all outputs are registered.

IDLE, evaluated every cycle:
- A client whose ack is high this cycle is not considered.
- Rejected requests:
  - relse by a non-owner, or hold by the current owner.
  - Result: ack+err pulse next cycle, no op issued, stay IDLE.
- Stalled requests:
  - any cmd from a client while the other client owns the lock.
  - Result: no ack, request remains pending.
- Eligible requests: owner NONE or requester is owner, and not rejected.
- Priority order:
  - rst_pend or soft_rst first.
  - Then, if both clients are eligible, the client at the round-robin pointer wins; the pointer then flips to the other client.
  - Otherwise the single eligible client wins.
- Rejection and issue are mutually exclusive per client. If A is rejected and B is issued in the same cycle, both proceed.
- On selection:
  - Load op (mapped as below), op_addr, op_wdata.
  - Set op_valid=1 and go to ISSUE.
  - For `rst`, op_addr and op_wdata are loaded with 0.
- Mapping to `operation_t`:
  - A read/write/hold/relse → a_read/a_write/a_hold/a_relse.
  - B → b_read/b_write/b_hold/b_relse.
  - soft_rst → `rst`.

ISSUE:
- op, op_addr and op_wdata stay stable while op_ready=0.
- On op_valid&&op_ready:
  - op_valid clears; return to IDLE.
  - The selected client's ack pulses next cycle (`rst` acks no client).
  - owner update at the handshake: hold→requester, relse→NONE, `rst`→NONE (rst also clears rst_pend).
- soft_rst seen in ISSUE sets sticky rst_pend; it is served first on return to IDLE.

Latency:
- Request sampled in IDLE at cycle n → op_valid at n+1.
- With op_ready=1 → handshake at n+1, ack at n+2.
- Same-client throughput is one request per 3 cycles minimum.

Clients must keep req, cmd, addr and wdata stable until ack. Changes before ack are undefined.

Decomposition:
- csm_pkg gains:
  - req_cmd_t (cmd_read, cmd_write, cmd_hold, cmd_relse).
  - owner_t (OWN_NONE, OWN_A, OWN_B).
  - function to_op(owner_t client, req_cmd_t cmd) returning `operation_t`.
- One sub-module, csm_client_gate, instantiated per client: computes eligible, stalled and reject from req, cmd, owner and own-ack.
- Top level holds the FSM, round-robin pointer and output registers.

Test Plan:
- Reset check: hold rst_n=0 mid-ISSUE with op_valid=1 → op_valid=0, owner=0, acks=0 immediately, asynchronously; after release, no stale ack.
- A read, addr=3, op_ready=1 → op=a_read, op_addr=3, op_valid=1 at n+1; a_ack=1, a_err=0 at n+2.
- A write (addr 1, data 0x11) and B write (addr 2, data 0x22) both raised at the same time after reset → a_write issued first, then b_write with op_wdata=0x22; the next simultaneous pair is served B first.
- A hold → owner=1.
  - B write is stalled with no b_ack for 10 cycles.
  - A write passes; A relse → owner=0.
  - B write then issues within 2 cycles.
- B relse with owner=0 → b_ack=b_err=1 one cycle later, op_valid stays 0. A hold twice → second hold gets a_ack+a_err, owner stays 1.
- A read with op_ready=0 for 5 cycles → op/op_addr stable. soft_rst pulsed during that time → after the A handshake, op=`rst` issued next, owner=0, pending B request acked only after the `rst` handshake.
